// File: rtl/mem_rep_out_serializer.sv
// Reply-path parallel-to-serial stage: captures one head/addr/data message and emits it as
// 16-bit flits after an arbiter grant. Optional sticky proto_err output under REP_SER_PROTO_ERR_EN.
module mem_rep_out_serializer #(
  parameter int unsigned FlitW      = 16,
  parameter int unsigned MaxFlitIdx = 10,
  parameter logic [3:0]  DefFlitMax = 4'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_flit_max_rep,
  input  logic [3:0]       flit_max_rep,
  input  logic             v_rep_out,
  input  logic [FlitW-1:0] head_out_rep_out,
  input  logic [31:0]      addr_out_rep_out,
  input  logic [127:0]     data_out_rep_out,
  output logic [1:0]       m_rep_fsm_state,
  output logic             rep_req,
  input  logic             rep_grant,
  output logic [FlitW-1:0] flit_out,
  output logic             v_flit_out,
  output logic [1:0]       flit_ctrl,
  input  logic             flit_ready
`ifdef REP_SER_PROTO_ERR_EN
  ,
  output logic             proto_err
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHold = 2'b01,
    StSend = 2'b10,
    StBad  = 2'b11
  } state_e;

  localparam logic [3:0] MaxIdx = 4'(MaxFlitIdx);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         fmax_q, fmax_d;
  logic [3:0]         fmax_clamp;
  logic               load_msg;
  logic [FlitW-1:0]   head_q;
  logic [31:0]        addr_q;
  logic [127:0]       data_q;

  // Entry MaxIdx holds the head, entry 0 holds data[15:0]; flit index k maps to entry MaxIdx-k.
  logic [MaxFlitIdx:0][FlitW-1:0] flits;
  assign flits = {head_q, addr_q, data_q};

  assign fmax_clamp      = (flit_max_rep > MaxIdx) ? MaxIdx : flit_max_rep;
  assign m_rep_fsm_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fmax_d     = fmax_q;
    load_msg   = 1'b0;
    rep_req    = 1'b0;
    v_flit_out = 1'b0;
    flit_out   = '0;
    flit_ctrl  = 2'b00;
    case (state_q)
      StIdle: begin
        if (en_flit_max_rep) fmax_d = fmax_clamp;
        if (v_rep_out) begin
          load_msg = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        rep_req = 1'b1;
        if (rep_grant) state_d = StSend;
      end
      StSend: begin
        v_flit_out = 1'b1;
        flit_out   = flits[MaxIdx - cnt_q];
        flit_ctrl  = {cnt_q == 4'd0, cnt_q == fmax_q};
        if (flit_ready) begin
          if (cnt_q == fmax_q) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            fmax_d  = DefFlitMax;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
        fmax_d  = DefFlitMax;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      fmax_q  <= DefFlitMax;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fmax_q  <= fmax_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (load_msg) begin
      head_q <= head_out_rep_out;
      addr_q <= addr_out_rep_out;
      data_q <= data_out_rep_out;
    end
  end

`ifdef REP_SER_PROTO_ERR_EN
  logic proto_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proto_err_q <= 1'b0;
    end else if ((v_rep_out && (state_q != StIdle)) ||
                 (en_flit_max_rep && (flit_max_rep > MaxIdx))) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule
